// File: rtl/z80fi_insn_capture.sv
// z80fi_insn_capture
//
// Collects the opcode bytes of one Z80 instruction as the core fetches them.
// It also records the IP/IX/IY values from before and after the instruction.
// When the instruction retires, it emits one packet on the z80fi_* outputs.
//
// Ports
//   clk                 single clock, all state on rising edge
//   reset               asynchronous, active-high; clears all state
//   fetch_valid         core fetched one instruction byte this cycle
//   fetch_byte[7:0]     fetched byte, qualified by fetch_valid
//   insn_done           last cycle of the current instruction; live
//                       registers already hold post-instruction values
//   reg_ip/ix/iy[15:0]  live architectural registers
//   z80fi_valid         one-cycle packet strobe
//   z80fi_insn[31:0]    captured bytes, first byte in [7:0], unused bytes 0
//   z80fi_insn_len[2:0] byte count 1..4 (0 only straight out of reset)
//   z80fi_reg_*_in/out  register values before / after the instruction
//   insn_error          one-cycle strobe with z80fi_valid when the
//                       instruction supplied more than 4 bytes
//   dbg_state           current FSM state (0 = IDLE, 1 = CAPTURE)
//
// Handshake: there is no back-pressure. z80fi_valid is a pure valid strobe
// with no ready. The packet fields are registered and stay stable from one
// strobe until the next one. A consumer may sample them on the strobe cycle
// or at any time afterwards.

module z80fi_insn_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [7:0]  fetch_byte,
    input  logic        insn_done,
    input  logic [15:0] reg_ip,
    input  logic [15:0] reg_ix,
    input  logic [15:0] reg_iy,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [15:0] z80fi_reg_ip_out,
    output logic [15:0] z80fi_reg_ix_in,
    output logic [15:0] z80fi_reg_ix_out,
    output logic [15:0] z80fi_reg_iy_in,
    output logic [15:0] z80fi_reg_iy_out,
    output logic        insn_error,
    output logic        dbg_state
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t state, state_next;

    // Working copy of the instruction being collected.
    logic [31:0] w_insn;
    logic [2:0]  w_len;
    logic [15:0] w_ip_in, w_ix_in, w_iy_in;
    logic        w_ovf;

    // Next values of the working registers.
    logic [31:0] insn_next;
    logic [2:0]  len_next;
    logic        ovf_next;
    logic        start;     // first byte of a new instruction this cycle
    logic        complete;  // packet is latched into the output registers

    // Pre-instruction values as seen at completion time. A single-cycle
    // instruction has not been snapshotted yet, so it uses the live values.
    logic [15:0] ip_in_sel, ix_in_sel, iy_in_sel;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        insn_next  = w_insn;
        len_next   = w_len;
        ovf_next   = w_ovf;
        start      = 1'b0;
        complete   = 1'b0;

        case (state)
            IDLE: begin
                // insn_done without a fetch has no instruction to close,
                // so it is ignored here.
                if (fetch_valid) begin
                    start     = 1'b1;
                    insn_next = {24'h0, fetch_byte};
                    len_next  = 3'd1;
                    ovf_next  = 1'b0;
                    if (insn_done) begin
                        complete = 1'b1;
                    end else begin
                        state_next = CAPTURE;
                    end
                end
            end

            CAPTURE: begin
                // A byte that arrives together with insn_done still belongs
                // to this instruction. It is merged in before completion.
                if (fetch_valid) begin
                    if (w_len < 3'd4) begin
                        len_next = w_len + 3'd1;
                        case (w_len)
                            3'd1:    insn_next[15:8]  = fetch_byte;
                            3'd2:    insn_next[23:16] = fetch_byte;
                            3'd3:    insn_next[31:24] = fetch_byte;
                            default: insn_next[7:0]   = fetch_byte;
                        endcase
                    end else begin
                        // Fifth and later bytes are dropped. The length
                        // saturates at 4 and never wraps.
                        ovf_next = 1'b1;
                    end
                end
                if (insn_done) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ip_in_sel = w_ip_in;
        ix_in_sel = w_ix_in;
        iy_in_sel = w_iy_in;
        if (start) begin
            ip_in_sel = reg_ip;
            ix_in_sel = reg_ix;
            iy_in_sel = reg_iy;
        end
    end

    // Working registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_insn  <= 32'h0;
            w_len   <= 3'd0;
            w_ip_in <= 16'h0;
            w_ix_in <= 16'h0;
            w_iy_in <= 16'h0;
            w_ovf   <= 1'b0;
        end else begin
            w_insn <= insn_next;
            w_len  <= len_next;
            // The overflow flag belongs to one packet only.
            w_ovf  <= complete ? 1'b0 : ovf_next;
            if (start) begin
                w_ip_in <= reg_ip;
                w_ix_in <= reg_ix;
                w_iy_in <= reg_iy;
            end
        end
    end

    // Packet output registers. The strobes last one cycle. The data fields
    // hold their values until the next completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z80fi_valid      <= 1'b0;
            insn_error       <= 1'b0;
            z80fi_insn       <= 32'h0;
            z80fi_insn_len   <= 3'd0;
            z80fi_reg_ip_in  <= 16'h0;
            z80fi_reg_ix_in  <= 16'h0;
            z80fi_reg_iy_in  <= 16'h0;
            z80fi_reg_ip_out <= 16'h0;
            z80fi_reg_ix_out <= 16'h0;
            z80fi_reg_iy_out <= 16'h0;
        end else begin
            z80fi_valid <= complete;
            insn_error  <= complete & ovf_next;
            if (complete) begin
                z80fi_insn       <= insn_next;
                z80fi_insn_len   <= len_next;
                z80fi_reg_ip_in  <= ip_in_sel;
                z80fi_reg_ix_in  <= ix_in_sel;
                z80fi_reg_iy_in  <= iy_in_sel;
                z80fi_reg_ip_out <= reg_ip;
                z80fi_reg_ix_out <= reg_ix;
                z80fi_reg_iy_out <= reg_iy;
            end
        end
    end

endmodule
